// File: rtl/aes_round_sequencer.sv
// AES round control sequencer: takes one block per valid/ready handshake and steps
// the state/key banks through LOAD, NUM_ROUNDS rounds and an output hold.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ld_state,
    output logic       ld_key,
    output logic       round_en,
    output logic [3:0] round_idx,
    output logic       final_round,
    output logic [7:0] rcon,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
        $fatal(1, "aes_round_sequencer: NUM_ROUNDS must be 10, 12 or 14");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_HOLD
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] rcon_q, rcon_d;
    logic       rdy_q;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // rdy_q keeps in_ready low through reset and up to the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rcon_q  <= 8'h00;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            rdy_q   <= 1'b1;
        end
    end

    assign in_ready = rdy_q && !flush &&
                      (state_q == S_IDLE || (state_q == S_HOLD && out_ready));
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcon_d      = rcon_q;
        ld_state    = 1'b0;
        ld_key      = 1'b0;
        round_en    = 1'b0;
        round_idx   = 4'd0;
        final_round = 1'b0;
        rcon        = 8'h00;
        out_valid   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) state_d = S_LOAD;
            end
            S_LOAD: begin
                ld_state = 1'b1;
                ld_key   = 1'b1;
                cnt_d    = 4'd1;
                rcon_d   = 8'h01;
                state_d  = S_ROUND;
            end
            S_ROUND: begin
                round_en  = 1'b1;
                round_idx = cnt_q;
                rcon      = rcon_q;
                cnt_d     = 4'(cnt_q + 4'd1);
                rcon_d    = xtime(rcon_q);
                if (cnt_q == LAST_ROUND) state_d = S_FINAL;
            end
            S_FINAL: begin
                round_en    = 1'b1;
                final_round = 1'b1;
                round_idx   = cnt_q;
                rcon        = rcon_q;
                cnt_d       = 4'd0;
                rcon_d      = 8'h00;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                // A waiting request goes straight to LOAD so back-to-back blocks see no bubble.
                if (out_ready) state_d = in_valid ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            rcon_d  = 8'h00;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: NUM_ROUNDS=10 and 14 instances checked each cycle
// against a transaction-age reference model plus directed latency/flush/reset steps.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fl   [2];
    logic       iv   [2];
    logic       ordy [2];
    logic       ir   [2];
    logic       lds  [2];
    logic       ldk  [2];
    logic       ren  [2];
    logic [3:0] ridx [2];
    logic       fr   [2];
    logic [7:0] rc   [2];
    logic       ov   [2];
    logic       bsy  [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] rcon_tab [0:13] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                    8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d};

    always #5 clk = ~clk;

    aes_round_sequencer #(.NUM_ROUNDS(10)) u_dut10 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .ld_state(lds[0]), .ld_key(ldk[0]), .round_en(ren[0]), .round_idx(ridx[0]),
        .final_round(fr[0]), .rcon(rc[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .busy(bsy[0])
    );

    aes_round_sequencer #(.NUM_ROUNDS(14)) u_dut14 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .ld_state(lds[1]), .ld_key(ldk[1]), .round_en(ren[1]), .round_idx(ridx[1]),
        .final_round(fr[1]), .rcon(rc[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .busy(bsy[1])
    );

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Reference model: age = cycles since the block was accepted (0 = idle).
    int age [2] = '{0, 0};
    bit mrdy = 1'b0;

    function automatic int nr(input int i);
        return (i == 0) ? 10 : 14;
    endfunction

    function automatic logic m_ir(input int i);
        return mrdy && !fl[i] && (age[i] == 0 || (age[i] >= nr(i) + 2 && ordy[i]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mrdy   <= 1'b0;
            age[0] <= 0;
            age[1] <= 0;
        end else begin
            mrdy <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (fl[i])                  age[i] <= 0;
                else if (age[i] == 0)       age[i] <= (iv[i] && m_ir(i)) ? 1 : 0;
                else if (age[i] >= nr(i) + 2) begin
                    if (ordy[i])            age[i] <= iv[i] ? 1 : 0;
                end else                    age[i] <= age[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int a, n;
            logic e_ren;
            a = age[i];
            n = nr(i);
            e_ren = (a >= 2 && a <= n + 1);
            chk($sformatf("m%0d in_ready", i),    ir[i],   m_ir(i));
            chk($sformatf("m%0d ld_state", i),    lds[i],  a == 1);
            chk($sformatf("m%0d ld_key", i),      ldk[i],  a == 1);
            chk($sformatf("m%0d round_en", i),    ren[i],  e_ren);
            chk($sformatf("m%0d round_idx", i),   ridx[i], e_ren ? a - 1 : 0);
            chk($sformatf("m%0d final_round", i), fr[i],   a == n + 1);
            chk($sformatf("m%0d rcon", i),        rc[i],   e_ren ? rcon_tab[a-2] : 8'h00);
            chk($sformatf("m%0d out_valid", i),   ov[i],   a >= n + 2);
            chk($sformatf("m%0d busy", i),        bsy[i],  a != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, prev, n_ov, cyc;
        logic [7:0] frc;
        logic [3:0] fidx;
        for (int i = 0; i < 2; i++) begin
            fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
        end
        #1 rst = 1'b1;
        #1 chk("rst in_ready", ir[0], 0);
        chk("rst busy", bsy[0], 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready before first edge", ir[0], 0);
        step();
        chk("ready after first edge", ir[0], 1);
        chk("idle busy", bsy[0], 0);

        // Single block, exact cycle-by-cycle latency
        repeat ($urandom_range(0, 3)) step();
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1 chk("blk accept ready", ir[0], 1);
        step();
        iv[0] = 1'b0;
        chk("blk c1 ld_state", lds[0], 1);
        chk("blk c1 ld_key", ldk[0], 1);
        chk("blk c1 round_en", ren[0], 0);
        for (int c = 2; c <= 11; c++) begin
            step();
            chk($sformatf("blk c%0d round_en", c), ren[0], 1);
            chk($sformatf("blk c%0d round_idx", c), ridx[0], c - 1);
            chk($sformatf("blk c%0d rcon", c), rc[0], rcon_tab[c-2]);
            chk($sformatf("blk c%0d final", c), fr[0], c == 11);
        end
        step();
        chk("blk c12 out_valid", ov[0], 1);
        step();
        chk("blk c13 idle", bsy[0], 0);
        chk("blk c13 ready", ir[0], 1);

        // Backpressure in HOLD
        repeat ($urandom_range(0, 3)) step();
        iv[0] = 1'b1; ordy[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        k = 0;
        while (!ov[0] && k < 40) begin step(); k++; end
        chk("bp cycles to hold", k, 11);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp out_valid held", ov[0], 1);
            chk("bp round_en", ren[0], 0);
            chk("bp ld_state", lds[0], 0);
            chk("bp rcon", rc[0], 0);
            chk("bp round_idx", ridx[0], 0);
        end
        ordy[0] = 1'b1;
        #1 chk("bp release ready", ir[0], 1);
        step();
        chk("bp back to idle", bsy[0], 0);
        chk("bp out_valid drop", ov[0], 0);

        // Back-to-back: out_valid period 12
        iv[0] = 1'b1; ordy[0] = 1'b1;
        prev = -1; n_ov = 0;
        for (int c = 0; c < 80 && n_ov < 3; c++) begin
            step();
            if (ov[0]) begin
                if (prev >= 0) chk("b2b period", c - prev, 12);
                chk("b2b ready in hold", ir[0], 1);
                prev = c;
                n_ov++;
            end
        end
        chk("b2b out_valid count", n_ov, 3);
        step();
        chk("b2b reload after hold", lds[0], 1);
        iv[0] = 1'b0;
        k = 0;
        while (bsy[0] && k < 40) begin step(); k++; end
        chk("b2b drained", bsy[0], 0);

        // Asynchronous reset mid-round
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        k = 0;
        while (ridx[0] != 4'd5 && k < 20) begin step(); k++; end
        chk("rst reach idx5", ridx[0], 5);
        rst = 1'b1;
        #1;
        chk("rst now round_en", ren[0], 0);
        chk("rst now round_idx", ridx[0], 0);
        chk("rst now rcon", rc[0], 0);
        chk("rst now busy", bsy[0], 0);
        chk("rst now in_ready", ir[0], 0);
        step();
        rst = 1'b0;
        #1 chk("rst rel ready low", ir[0], 0);
        step();
        chk("rst rel ready", ir[0], 1);
        chk("rst rel busy", bsy[0], 0);
        chk("rst rel idx", ridx[0], 0);

        // Flush mid-round at round_idx 3
        iv[0] = 1'b1; ordy[0] = 1'b0;
        step();
        iv[0] = 1'b0;
        k = 0;
        while (ridx[0] != 4'd3 && k < 20) begin step(); k++; end
        chk("fl reach idx3", ridx[0], 3);
        fl[0] = 1'b1; iv[0] = 1'b1;
        #1 chk("fl round ready", ir[0], 0);
        step();
        fl[0] = 1'b0; iv[0] = 1'b0;
        chk("fl round busy", bsy[0], 0);
        chk("fl round rcon", rc[0], 0);
        chk("fl round idx", ridx[0], 0);
        chk("fl round no load", lds[0], 0);

        // Flush in HOLD while a handshake and new request are presented
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        k = 0;
        while (!ov[0] && k < 40) begin step(); k++; end
        chk("fl reach hold", ov[0], 1);
        fl[0] = 1'b1; ordy[0] = 1'b1; iv[0] = 1'b1;
        #1 chk("fl hold ready", ir[0], 0);
        step();
        fl[0] = 1'b0; iv[0] = 1'b0;
        chk("fl hold busy", bsy[0], 0);
        chk("fl hold no load", lds[0], 0);
        chk("fl hold out_valid", ov[0], 0);

        // NUM_ROUNDS=14 single block
        iv[1] = 1'b1; ordy[1] = 1'b1;
        step();
        iv[1] = 1'b0;
        cyc = 1; frc = 8'h00; fidx = 4'd0;
        while (!ov[1] && cyc < 40) begin
            if (fr[1]) begin frc = rc[1]; fidx = ridx[1]; end
            step();
            cyc++;
        end
        chk("r14 out_valid cycle", cyc, 16);
        chk("r14 final rcon", frc, 8'h4d);
        chk("r14 final idx", fidx, 14);
        step();
        chk("r14 idle", bsy[1], 0);

        // Random traffic on both instances against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                iv[i]   = 1'($urandom_range(0, 1));
                ordy[i] = ($urandom_range(0, 3) != 0);
                fl[i]   = ($urandom_range(0, 39) == 0);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
